// File: rtl/hazard_scoreboard_pkg.sv
// Shared control-path types for the hazard unit: result source and forward select encodings.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        RESULT_SRC_ALU    = 2'b00,
        RESULT_SRC_MEMORY = 2'b01,
        RESULT_SRC_PC4    = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } forward_sel_t;

    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/hazard_scoreboard_reg_scoreboard.sv
// Per-register pending bits for long-latency ops, in-flight count and sticky protocol error.
module reg_scoreboard #(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = $clog2(NUM_REGS),
    parameter int LONG_DEPTH = 4,
    parameter int CNT_W      = $clog2(LONG_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_issue,
    input  logic [REG_ADDR_W-1:0] i_issue_rd,
    input  logic                  i_wb_valid,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    input  logic [REG_ADDR_W-1:0] i_rd,
    output logic                  o_pend_rs1,
    output logic                  o_pend_rs2,
    output logic                  o_pend_rd,
    output logic [CNT_W-1:0]      o_count,
    output logic [NUM_REGS-1:0]   o_pending,
    output logic                  o_err
);

    logic [NUM_REGS-1:0] r_pending;
    logic [CNT_W-1:0]    r_count;
    logic                r_err;
    logic [NUM_REGS-1:0] w_pending_nxt;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                w_err_ev;

    // Clear before set so a same-edge issue to the written-back register stays pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_wb_valid) begin
            w_pending_nxt[i_wb_rd] = 1'b0;
        end
        if (i_issue && (i_issue_rd != '0)) begin
            w_pending_nxt[i_issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_comb begin
        w_count_nxt = r_count;
        if (i_issue && !i_wb_valid) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!i_issue && i_wb_valid && (r_count != '0)) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    assign w_err_ev = i_wb_valid &&
                      ((r_count == '0) || ((i_wb_rd != '0) && !r_pending[i_wb_rd]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_count   <= w_count_nxt;
            r_err     <= r_err | w_err_ev;
        end
    end

    assign o_pend_rs1 = r_pending[i_rs1];
    assign o_pend_rs2 = r_pending[i_rs2];
    assign o_pend_rd  = r_pending[i_rd];
    assign o_count    = r_count;
    assign o_pending  = r_pending;
    assign o_err      = r_err;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: forwarding, load-use/scoreboard stalls, long-unit structural stall, flushes.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = $clog2(NUM_REGS),
    parameter int LONG_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] d_rs1,
    input  logic [REG_ADDR_W-1:0] d_rs2,
    input  logic [REG_ADDR_W-1:0] d_rd,
    input  logic                  d_reg_write,
    input  logic [REG_ADDR_W-1:0] e_rs1,
    input  logic [REG_ADDR_W-1:0] e_rs2,
    input  logic [REG_ADDR_W-1:0] e_rd,
    input  logic [REG_ADDR_W-1:0] m_rd,
    input  logic [REG_ADDR_W-1:0] w_rd,
    input  logic                  e_pc_src,
    input  result_src_t           e_result_src,
    input  logic                  e_long_op,
    input  logic                  m_reg_write,
    input  logic                  w_reg_write,
    input  logic                  lu_wb_valid,
    input  logic [REG_ADDR_W-1:0] lu_wb_rd,
    output logic                  f_stall,
    output logic                  d_stall,
    output logic                  e_stall,
    output logic                  d_flush,
    output logic                  e_flush,
    output logic                  m_flush,
    output forward_sel_t          e_forward_a,
    output forward_sel_t          e_forward_b,
    output logic [NUM_REGS-1:0]   sb_pending,
    output logic                  sb_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_stall_cyc,
    output logic [PERF_CNT_W-1:0] perf_struct_cyc,
    output logic [PERF_CNT_W-1:0] perf_flush_cyc
`endif
);

    localparam int CNT_W = $clog2(LONG_DEPTH + 1);

    logic             w_pend_rs1;
    logic             w_pend_rs2;
    logic             w_pend_rd;
    logic [CNT_W-1:0] w_count;
    logic             w_lw_stall;
    logic             w_e_long_hit;
    logic             w_sb_stall;
    logic             w_lu_full;
    logic             w_issue;

    function automatic forward_sel_t fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                             input logic [REG_ADDR_W-1:0] mrd,
                                             input logic                  mwe,
                                             input logic [REG_ADDR_W-1:0] wrd,
                                             input logic                  wwe);
        if ((rs != '0) && mwe && (mrd == rs)) begin
            return FWD_MEM;
        end else if ((rs != '0) && wwe && (wrd == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    reg_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .REG_ADDR_W (REG_ADDR_W),
        .LONG_DEPTH (LONG_DEPTH),
        .CNT_W      (CNT_W)
    ) u_reg_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_issue    (w_issue),
        .i_issue_rd (e_rd),
        .i_wb_valid (lu_wb_valid),
        .i_wb_rd    (lu_wb_rd),
        .i_rs1      (d_rs1),
        .i_rs2      (d_rs2),
        .i_rd       (d_rd),
        .o_pend_rs1 (w_pend_rs1),
        .o_pend_rs2 (w_pend_rs2),
        .o_pend_rd  (w_pend_rd),
        .o_count    (w_count),
        .o_pending  (sb_pending),
        .o_err      (sb_err)
    );

    assign e_forward_a = fwd_sel(e_rs1, m_rd, m_reg_write, w_rd, w_reg_write);
    assign e_forward_b = fwd_sel(e_rs2, m_rd, m_reg_write, w_rd, w_reg_write);

    assign w_lw_stall = (e_result_src == RESULT_SRC_MEMORY) && (e_rd != '0) &&
                        ((d_rs1 == e_rd) || (d_rs2 == e_rd));

    // A long op sitting in E is not yet in the scoreboard, so D must compare against it directly.
    assign w_e_long_hit = e_long_op && (e_rd != '0) &&
                          ((d_rs1 == e_rd) || (d_rs2 == e_rd) || (d_reg_write && (d_rd == e_rd)));

    assign w_sb_stall = w_pend_rs1 || w_pend_rs2 || (d_reg_write && w_pend_rd) || w_e_long_hit;
    assign w_lu_full  = e_long_op && (w_count == CNT_W'(LONG_DEPTH)) && !lu_wb_valid;
    assign w_issue    = e_long_op && !w_lu_full;

    always_comb begin
        f_stall = 1'b0;
        d_stall = 1'b0;
        e_stall = 1'b0;
        d_flush = 1'b0;
        e_flush = 1'b0;
        m_flush = 1'b0;
        if (w_lu_full) begin
            f_stall = 1'b1;
            d_stall = 1'b1;
            e_stall = 1'b1;
            m_flush = 1'b1;
        end else begin
            f_stall = w_lw_stall || w_sb_stall;
            d_stall = w_lw_stall || w_sb_stall;
            e_flush = w_lw_stall || w_sb_stall || e_pc_src;
            d_flush = e_pc_src;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] r_perf_stall;
    logic [PERF_CNT_W-1:0] r_perf_struct;
    logic [PERF_CNT_W-1:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall  <= '0;
            r_perf_struct <= '0;
            r_perf_flush  <= '0;
        end else begin
            if (d_stall) begin
                r_perf_stall <= r_perf_stall + PERF_CNT_W'(1);
            end
            if (w_lu_full) begin
                r_perf_struct <= r_perf_struct + PERF_CNT_W'(1);
            end
            if (d_flush || e_flush) begin
                r_perf_flush <= r_perf_flush + PERF_CNT_W'(1);
            end
        end
    end

    assign perf_stall_cyc  = r_perf_stall;
    assign perf_struct_cyc = r_perf_struct;
    assign perf_flush_cyc  = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed bench for hazard_scoreboard with a queue-based scoreboard and reference model.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int LD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic [AW-1:0] d_rs1, d_rs2, d_rd, e_rs1, e_rs2, e_rd, m_rd, w_rd, lu_wb_rd;
    logic d_reg_write, e_pc_src, e_long_op, m_reg_write, w_reg_write, lu_wb_valid;
    result_src_t e_result_src;
    logic f_stall, d_stall, e_stall, d_flush, e_flush, m_flush, sb_err;
    forward_sel_t e_forward_a, e_forward_b;
    logic [NR-1:0] sb_pending;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cyc, perf_struct_cyc, perf_flush_cyc;
`endif

    hazard_scoreboard #(.NUM_REGS(NR), .REG_ADDR_W(AW), .LONG_DEPTH(LD)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_reg_write(d_reg_write),
        .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd), .m_rd(m_rd), .w_rd(w_rd),
        .e_pc_src(e_pc_src), .e_result_src(e_result_src), .e_long_op(e_long_op),
        .m_reg_write(m_reg_write), .w_reg_write(w_reg_write),
        .lu_wb_valid(lu_wb_valid), .lu_wb_rd(lu_wb_rd),
        .f_stall(f_stall), .d_stall(d_stall), .e_stall(e_stall),
        .d_flush(d_flush), .e_flush(e_flush), .m_flush(m_flush),
        .e_forward_a(e_forward_a), .e_forward_b(e_forward_b),
        .sb_pending(sb_pending), .sb_err(sb_err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cyc(perf_stall_cyc), .perf_struct_cyc(perf_struct_cyc),
        .perf_flush_cyc(perf_flush_cyc)
`endif
    );

    typedef struct packed {
        logic [5:0]  ctl;   // f_stall,d_stall,e_stall,d_flush,e_flush,m_flush
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] pend;
        logic        err;
        logic [31:0] p_st;
        logic [31:0] p_sc;
        logic [31:0] p_fl;
    } exp_t;

    exp_t q[$];
    event ev_chk;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference state: set of pending registers, list of in-flight destinations, sticky error.
    bit [NR-1:0]  m_pend;
    int           m_inflight[$];
    bit           m_err;
    int unsigned  m_st, m_sc, m_fl;

    function automatic logic [1:0] fwd_model(input logic [AW-1:0] rs);
        if (rs != 0 && m_reg_write && m_rd == rs) return 2'b10;
        if (rs != 0 && w_reg_write && w_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit model_full();
        return e_long_op && (m_inflight.size() == LD) && !lu_wb_valid;
    endfunction

    task automatic model_reset();
        m_pend = '0;
        m_inflight.delete();
        m_err = 0;
        m_st = 0; m_sc = 0; m_fl = 0;
    endtask

    task automatic compute(output exp_t e);
        bit lw, sb, hz, full;
        lw = (e_result_src == RESULT_SRC_MEMORY) && e_rd != 0 && (d_rs1 == e_rd || d_rs2 == e_rd);
        sb = m_pend[d_rs1] || m_pend[d_rs2] || (d_reg_write && m_pend[d_rd]) ||
             (e_long_op && e_rd != 0 &&
              (d_rs1 == e_rd || d_rs2 == e_rd || (d_reg_write && d_rd == e_rd)));
        hz = lw || sb;
        full = model_full();
        if (full) e.ctl = 6'b111001;
        else      e.ctl = {hz, hz, 1'b0, e_pc_src, hz || e_pc_src, 1'b0};
        e.fa   = fwd_model(e_rs1);
        e.fb   = fwd_model(e_rs2);
        e.pend = m_pend;
        e.err  = m_err;
        e.p_st = m_st;
        e.p_sc = m_sc;
        e.p_fl = m_fl;
    endtask

    task automatic model_update(input exp_t e);
        bit full, issue;
        int cnt;
        full  = model_full();
        issue = e_long_op && !full;
        cnt   = m_inflight.size();
        if (e.ctl[4]) m_st++;
        if (full) m_sc++;
        if (e.ctl[2] || e.ctl[1]) m_fl++;
        if (lu_wb_valid) begin
            if (cnt == 0) m_err = 1;
            if (lu_wb_rd != 0 && !m_pend[lu_wb_rd]) m_err = 1;
            m_pend[lu_wb_rd] = 0;
            for (int i = 0; i < m_inflight.size(); i++) begin
                if (m_inflight[i] == int'(lu_wb_rd)) begin
                    m_inflight.delete(i);
                    break;
                end
            end
        end
        if (issue) begin
            if (e_rd != 0) m_pend[e_rd] = 1;
            m_inflight.push_back(int'(e_rd));
        end
    endtask

    // Call after driving inputs at a negedge: queues the expectation and advances one clock.
    task automatic step();
        exp_t e;
        compute(e);
        q.push_back(e);
        -> ev_chk;
        @(posedge clk);
        if (rst_n) model_update(e);
        cyc++;
    endtask

    task automatic idle();
        d_rs1 = 0; d_rs2 = 0; d_rd = 0; d_reg_write = 0;
        e_rs1 = 0; e_rs2 = 0; e_rd = 0; m_rd = 0; w_rd = 0;
        e_pc_src = 0; e_result_src = RESULT_SRC_ALU; e_long_op = 0;
        m_reg_write = 0; w_reg_write = 0; lu_wb_valid = 0; lu_wb_rd = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 0;
        model_reset();
        step();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(ev_chk);
            #1;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL queue cyc=%0d got=empty expected=entry", cyc);
            end else begin
                e = q.pop_front();
                chk("ctl", 32'({f_stall, d_stall, e_stall, d_flush, e_flush, m_flush}), 32'(e.ctl));
                chk("fwd_a", 32'(e_forward_a), 32'(e.fa));
                chk("fwd_b", 32'(e_forward_b), 32'(e.fb));
                chk("pending", sb_pending, e.pend);
                chk("sb_err", 32'(sb_err), 32'(e.err));
`ifdef HAZARD_PERF_CNT_EN
                chk("perf_stall", perf_stall_cyc, e.p_st);
                chk("perf_struct", perf_struct_cyc, e.p_sc);
                chk("perf_flush", perf_flush_cyc, e.p_fl);
`endif
            end
        end
    end

    initial begin : driver
        idle();
        rst_n = 1;
        model_reset();
        #2 rst_n = 0;
        do_reset();

        // forwarding priority and x0
        idle(); m_rd = 5; e_rs1 = 5; m_reg_write = 1; w_rd = 5; w_reg_write = 1; step();
        @(negedge clk); e_rs1 = 0; e_rs2 = 5; m_reg_write = 0; step();
        // load-use
        @(negedge clk); idle(); e_result_src = RESULT_SRC_MEMORY; e_rd = 7; d_rs2 = 7; step();
        @(negedge clk); e_rd = 0; step();
        // long op scoreboard stall and release
        @(negedge clk); idle(); e_long_op = 1; e_rd = 9; d_rs1 = 9; step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); d_rs1 = 9; step();
        end
        @(negedge clk); lu_wb_valid = 1; lu_wb_rd = 9; step();
        @(negedge clk); idle(); d_rs1 = 9; step();
        // fill the long unit
        for (int i = 0; i < LD; i++) begin
            @(negedge clk); idle(); e_long_op = 1; e_rd = AW'(10 + i); step();
        end
        @(negedge clk); idle(); e_long_op = 1; e_rd = 14; step();
        @(negedge clk); lu_wb_valid = 1; lu_wb_rd = 10; step();
        for (int i = 11; i <= 14; i++) begin
            @(negedge clk); idle(); lu_wb_valid = 1; lu_wb_rd = AW'(i); step();
        end
        // branch flush
        @(negedge clk); idle(); e_pc_src = 1; step();
        // write-back to a non-pending register
        @(negedge clk); idle(); lu_wb_valid = 1; lu_wb_rd = 3; step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle(); step();
        end
        do_reset();
        // reset while a long op is in flight, then its late write-back
        idle(); e_long_op = 1; e_rd = 9; step();
        do_reset();
        idle(); lu_wb_valid = 1; lu_wb_rd = 9; step();
        do_reset();

        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            d_rs1 = AW'($urandom_range(0, 7)); d_rs2 = AW'($urandom_range(0, 7));
            d_rd = AW'($urandom_range(0, 7)); d_reg_write = 1'($urandom);
            e_rs1 = AW'($urandom_range(0, 7)); e_rs2 = AW'($urandom_range(0, 7));
            e_rd = AW'($urandom_range(0, 7));
            m_rd = AW'($urandom_range(0, 7)); w_rd = AW'($urandom_range(0, 7));
            m_reg_write = 1'($urandom); w_reg_write = 1'($urandom);
            e_result_src = result_src_t'($urandom_range(0, 2));
            e_long_op = ($urandom_range(0, 2) == 0);
            e_pc_src = ($urandom_range(0, 7) == 0);
            if (e_long_op) begin
                e_pc_src = 0;
                if (e_rd != 0 && m_pend[e_rd]) e_rd = 0;
            end
            if (m_inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
                lu_wb_valid = 1;
                lu_wb_rd = AW'(m_inflight[$urandom_range(0, m_inflight.size() - 1)]);
            end else begin
                lu_wb_valid = 0;
                lu_wb_rd = AW'($urandom_range(0, 7));
            end
            step();
        end

        @(negedge clk);
        idle();
        #3;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
